// File: rtl/serial_pattern_tx.sv
// Serial pattern source: emits a captured word MSB-first on a 1-bit valid/data link,
// repeated a programmable number of times with programmable idle gaps after each bit.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int GAP_W = 3,
    parameter int REP_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_word,
    input  logic [LEN_W-1:0] i_len,
    input  logic [GAP_W-1:0] i_gap,
    input  logic [REP_W-1:0] i_rep,
    output logic             o_valid,
    output logic             o_data,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    // Requested lengths beyond the word width saturate to the full word.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gcfg_q, gcfg_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] len_eff;
    logic             valid_d, data_d, busy_d, done_d;

    assign len_eff = sat_len(i_len);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        gcfg_d  = gcfg_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    word_d = i_word;
                    len_d  = len_eff;
                    gcfg_d = i_gap;
                    rep_d  = i_rep;
                    if (len_eff == '0 || i_rep == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND;
                        idx_d   = len_eff - LEN_ONE;
                    end
                end
            end
            S_SEND: begin
                if (idx_q == '0 && rep_q == REP_ONE) begin
                    state_d = S_DONE;
                end else begin
                    // Advance to the next bit, wrapping into the next repetition.
                    if (idx_q != '0) begin
                        idx_d = idx_q - LEN_ONE;
                    end else begin
                        idx_d = len_q - LEN_ONE;
                        rep_d = rep_q - REP_ONE;
                    end
                    if (gcfg_q != '0) begin
                        state_d = S_GAP;
                        gap_d   = gcfg_q;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - GAP_ONE;
                if (gap_q == GAP_ONE) begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the first bit appears one cycle after start.
    always_comb begin
        valid_d = (state_d == S_SEND);
        data_d  = valid_d & (|(word_d & (WIDTH'(1) << idx_d)));
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            gcfg_q  <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            gcfg_q  <= gcfg_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            o_valid <= valid_d;
            o_data  <= data_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        word_q <= word_d;
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: table of frames with per-cycle expected
// valid/data/busy/done masks, plus reset, busy-ignore and 1101-loopback sequences.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] word;
    logic [3:0] len;
    logic [2:0] gap;
    logic [2:0] rep;
    logic       o_valid, o_data, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  word;
        logic [3:0]  len;
        logic [2:0]  gap;
        logic [2:0]  rep;
        int          busy;   // cycle number of the o_done pulse (= busy cycles)
        logic [63:0] ev;     // bit k-1 = expected o_valid in cycle k
        logic [63:0] ed;     // bit k-1 = expected o_data in cycle k
    } vec_t;

    vec_t vecs[10];

    logic       det_clr = 1'b0;
    logic [3:0] det_sh  = 4'd0;
    int         det_cnt = 0;

    serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_W(3), .REP_W(3)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_word (word),
        .i_len  (len),
        .i_gap  (gap),
        .i_rep  (rep),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    always #5 clk = ~clk;

    // Overlapping "1101" detector consuming only valid beats.
    always @(negedge clk) begin
        if (det_clr) begin
            det_sh  <= 4'd0;
            det_cnt <= 0;
        end else if (o_valid) begin
            det_sh <= {det_sh[2:0], o_data};
            if ({det_sh[2:0], o_data} == 4'b1101) det_cnt <= det_cnt + 1;
        end
    end

    task automatic check4(input int tag, input int cyc, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL vec%0d cyc%0d {valid,data,busy,done} got %b exp %b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_det(input int tag, input int exp);
        checks++;
        if (det_cnt != exp) begin
            errors++;
            $display("FAIL loopback%0d detect_count got %0d exp %0d", tag, det_cnt, exp);
        end
    endtask

    task automatic expect_cycle(input int tag, input int k, input vec_t v);
        check4(tag, k, {o_valid, o_data, o_busy, o_done},
               {v.ev[k-1], v.ed[k-1], (k <= v.busy), (k == v.busy)});
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        word  = v.word;
        len   = v.len;
        gap   = v.gap;
        rep   = v.rep;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        word  = ~v.word;
        len   = ~v.len;
        gap   = ~v.gap;
        rep   = ~v.rep;
    endtask

    task automatic run_vec(input int tag, input vec_t v);
        launch(v);
        for (int k = 1; k <= v.busy + 1; k++) begin
            @(negedge clk);
            expect_cycle(tag, k, v);
        end
    endtask

    task automatic clear_det();
        det_clr = 1'b1;
        @(negedge clk);
        det_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h0D, 4'd4,  3'd0, 3'd2, 9,  64'hFF,  64'hBB};
        vecs[1] = '{8'h0D, 4'd4,  3'd2, 3'd1, 11, 64'h249, 64'h209};
        vecs[2] = '{8'h0D, 4'd0,  3'd0, 3'd3, 1,  64'h0,   64'h0};
        vecs[3] = '{8'h0D, 4'd4,  3'd0, 3'd0, 1,  64'h0,   64'h0};
        vecs[4] = '{8'hA5, 4'd15, 3'd0, 3'd1, 9,  64'hFF,  64'hA5};
        vecs[5] = '{8'h05, 4'd3,  3'd1, 3'd2, 12, 64'h555, 64'h451};
        vecs[6] = '{8'hC1, 4'd8,  3'd0, 3'd1, 9,  64'hFF,  64'h83};
        vecs[7] = '{8'h01, 4'd1,  3'd7, 3'd2, 10, 64'h101, 64'h101};
        vecs[8] = '{8'h0D, 4'd4,  3'd0, 3'd3, 13, 64'hFFF, 64'hBBB};
        vecs[9] = '{8'h0D, 4'd4,  3'd3, 3'd3, 46, 64'h1111_1111_1111, 64'h1011_1011_1011};

        // Reset dominates a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        word  = 8'hFF;
        len   = 4'd8;
        gap   = 3'd0;
        rep   = 3'd1;
        repeat (2) begin
            @(negedge clk);
            check4(100, 0, {o_valid, o_data, o_busy, o_done}, 4'b0000);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check4(100, 1, {o_valid, o_data, o_busy, o_done}, 4'b0000);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Busy-ignore: a different word requested during cycles 2-9 must not disturb the frame.
        launch(vecs[4]);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 10) expect_cycle(104, k, vecs[4]);
            else check4(104, k, {o_valid, o_data, o_busy, o_done}, 4'b0000);
            start = (k >= 2 && k <= 9);
            word  = 8'h5A;
            len   = 4'd8;
            rep   = 3'd2;
            gap   = 3'd0;
        end
        start = 1'b0;

        // Reset in cycle 3 of a frame, then a fresh complete frame.
        launch(vecs[0]);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            expect_cycle(200, k, vecs[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        check4(200, 4, {o_valid, o_data, o_busy, o_done}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check4(200, 5, {o_valid, o_data, o_busy, o_done}, 4'b0000);
        run_vec(201, vecs[0]);

        // Loopback into the 1101 detector, with and without gaps.
        clear_det();
        run_vec(8, vecs[8]);
        check_det(0, 3);
        clear_det();
        run_vec(9, vecs[9]);
        check_det(1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial bit-stream transmitter: loads a parallel pattern word and emits it MSB-first, one bit per valid cycle, on a valid/data serial interface. Sends the pattern a programmable number of times, with programmable idle (valid-low) gaps between bits. Serves as the stimulus/source end of the team's 1-bit valid/data serial link, which feeds sequence-detecting consumers such as the "1101" detector path.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of i_len; must satisfy 2^LEN_W > WIDTH
GAP_W, 3, width of i_gap (idle cycles inserted after each bit)
REP_W, 3, width of i_rep (number of pattern repetitions)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  load request; accepted only when o_busy=0
i_word  input  WIDTH  pattern; bit i_len-1 sent first
i_len  input  LEN_W  pattern length in bits; 0 = empty frame
i_gap  input  GAP_W  valid-low cycles after each bit
i_rep  input  REP_W  repetitions; 0 = empty frame
o_valid  output  1  serial bit valid
o_data  output  1  serial bit; 0 whenever o_valid=0
o_busy  output  1  transfer in progress
o_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (i_rst=1 at an edge): o_valid=0, o_data=0, o_busy=0, o_done=0, FSM=IDLE, internal counters=0. Reset dominates every other input. A reset mid-transfer abandons the frame with no o_done pulse.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states:
  - IDLE: o_busy=0. If i_start=1, capture i_word, len_eff, i_gap and i_rep into registers (later input changes are ignored).
    - If len_eff=0 or i_rep=0, go to DONE.
    - Otherwise go to SEND with bit index=len_eff-1 and rep count=i_rep.
  - SEND: o_valid=1, o_data=word[idx], for exactly one cycle.
    - Last bit (idx=0 and final repetition): go to DONE.
    - Otherwise, if gap>0, go to GAP and load the gap counter with gap.
    - Otherwise stay in SEND with the next bit.
    - Next bit: if idx>0, idx-1. If idx=0, idx reloads to len_eff-1 and the rep count decrements (wrap to the next repetition).
  - GAP: o_valid=0, o_data=0. Counts down gap cycles, then returns to SEND.
  - DONE: o_done=1 and o_busy=1 for one cycle, o_valid=0. Then go to IDLE.
- Effective length: len_eff = min(i_len, WIDTH). Any value above WIDTH is clamped to WIDTH.
- No gap is inserted after the final bit of the final repetition. Gaps are inserted between repetitions exactly as between bits.
- Latency: if i_start is accepted at edge N, the first bit has o_valid=1 in cycle N+1.
  - Total busy cycles = len_eff*i_rep bit cycles + (len_eff*i_rep-1)*i_gap gap cycles + 1 DONE cycle.
  - An empty frame gives o_busy=1 and o_done=1 in cycle N+1 only.
- o_busy is 1 in SEND, GAP and DONE.
- i_start while o_busy=1 (including the DONE cycle) is ignored and not queued. A new start is accepted no earlier than the first IDLE cycle after DONE.
- Counters: idx has LEN_W bits, rep has REP_W bits, gap has GAP_W bits. None wraps past 0; each is reloaded only as specified above.

Test Plan:
1. Back-to-back, no gap: i_word=8'b0000_1101, i_len=4, i_rep=2, i_gap=0, start at edge 0.
   - o_valid=1 in cycles 1–8 with o_data=1,1,0,1,1,1,0,1.
   - o_done=1 in cycle 9; o_busy falls in cycle 10.
2. Gap insertion: same word, i_len=4, i_rep=1, i_gap=2.
   - Cycles 1–10 show valid pattern 1,0,0,1,0,0,1,0,0,1 with data 1,-,-,1,-,-,0,-,-,1 (data=0 while invalid).
   - o_done in cycle 11.
3. Empty frames:
   - i_len=0, i_rep=3 -> no o_valid; o_done and o_busy high in cycle 1 only.
   - i_rep=0, i_len=4 -> same response.
4. Clamp and busy-ignore: i_len=15, i_word=8'hA5, i_rep=1 -> 8 bits 1,0,1,0,0,1,0,1.
   - A second i_start with a different word during cycles 2–9 is ignored; output is unchanged.
5. Reset mid-operation: assert i_rst in cycle 3 of test 1.
   - Next cycle: all outputs 0, no o_done pulse.
   - A fresh start two cycles later transmits the full pattern correctly.
6. Loopback: drive a 1101 sequence-detector consumer with i_word=4'b1101, i_rep=3, gaps 0 and 3.
   - The consumer reports the expected detection count in both runs; gap cycles must not change the result.
